// File: rtl/mio_bridge.sv
// mio_bridge: bridges a multi-cycle CPU controller's memory requests onto a
// fixed-latency synchronous RAM or a handshaked peripheral bus.
// Accesses with addr[31:28] >= IO_BASE_NIB go to the peripheral bus; all
// others go to RAM.
// Optional feature: define MIO_TIMEOUT_EN to abort peripheral accesses that
// see no io_ack within IO_TIMEOUT cycles.
module mio_bridge #(
  parameter int unsigned RAM_LAT     = 1,
  parameter int unsigned IO_TIMEOUT  = 255,
  parameter logic [3:0]  IO_BASE_NIB = 4'hE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        CPU_MIO,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        MIO_ready,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        io_re,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [7:0] RamLatCnt = 8'(RAM_LAT);

  state_t     state;
  logic [7:0] cnt;
  logic       is_write;
  logic       request;
  logic       sel_io;

  assign request = CPU_MIO & (MemRead | MemWrite);
  assign sel_io  = (addr[31:28] >= IO_BASE_NIB);

`ifdef MIO_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(IO_TIMEOUT - 1);
`else
  // Timeout limit is meaningless without the watchdog.
  logic unused_timeout;
  assign unused_timeout = ^(8'(IO_TIMEOUT));
`endif

  // Access sequencer: all strobes, captured data and the completion pulse are
  // registered so the controller and the buses see glitch-free signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      is_write  <= 1'b0;
      MIO_ready <= 1'b0;
      rdata     <= 32'd0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 10'd0;
      ram_din   <= 32'd0;
      io_re     <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= 32'd0;
      io_wdata  <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      // Single-cycle pulses by default.
      MIO_ready <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (request) begin
            // Conflicting read+write resolves to a write and flags an error.
            is_write <= MemWrite;
            if (MemRead && MemWrite) bus_err <= 1'b1;
            if (sel_io) begin
              io_addr  <= addr;
              io_wdata <= wdata;
              io_re    <= ~MemWrite;
              io_we    <= MemWrite;
              cnt      <= 8'd0;
              state    <= IO_WAIT;
            end else begin
              ram_addr <= addr[11:2];
              ram_din  <= wdata;
              ram_en   <= 1'b1;
              ram_we   <= MemWrite;
              cnt      <= RamLatCnt;
              state    <= RAM_WAIT;
            end
          end
        end
        RAM_WAIT: begin
          if (cnt == 8'd0) begin
            if (!is_write) rdata <= ram_dout;
            MIO_ready <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        IO_WAIT: begin
          if (io_ack) begin
            if (!is_write) rdata <= io_rdata;
            io_re     <= 1'b0;
            io_we     <= 1'b0;
            cnt       <= 8'd0;
            MIO_ready <= 1'b1;
            state     <= DONE;
          end
`ifdef MIO_TIMEOUT_EN
          else if (cnt == TimeoutLast) begin
            if (!is_write) rdata <= 32'hFFFF_FFFF;
            io_re     <= 1'b0;
            io_we     <= 1'b0;
            bus_err   <= 1'b1;
            cnt       <= 8'd0;
            MIO_ready <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          // Requests are not sampled here; the controller sees MIO_ready now.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mio_bridge.md
MIO_BRIDGE -- requirements
Module: mio_bridge

Interface
REQ-001 Parameter RAM_LAT, 1, RAM read/write latency in cycles (1..7).
REQ-002 Parameter IO_TIMEOUT, 255, maximum cycles waited for io_ack (1..255).
REQ-003 Parameter IO_BASE_NIB, 4'hE, addr[31:28] values >= this select the peripheral bus; lower values select RAM.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 MemRead  in  1  read request from the multi-cycle controller.
REQ-007 MemWrite  in  1  write request from the multi-cycle controller.
REQ-008 CPU_MIO  in  1  memory/IO access qualifier from the controller.
REQ-009 addr  in  32  byte address (IorD-muxed PC or ALUOut).
REQ-010 wdata  in  32  store data (register B).
REQ-011 MIO_ready  out  1  one-cycle completion pulse to the controller.
REQ-012 rdata  out  32  read data to the IR/MDR.
REQ-013 ram_en, ram_we  out  1 each  RAM strobes.
REQ-014 ram_addr  out  10  RAM word address (addr[11:2]).
REQ-015 ram_din  out  32  RAM write data.  ram_dout  in  32  RAM read data.
REQ-016 io_re, io_we  out  1 each  peripheral strobes.  io_addr  out  32.  io_wdata  out  32.
REQ-017 io_rdata  in  32  peripheral read data.  io_ack  in  1  peripheral completion.
REQ-018 bus_err  out  1  sticky error flag.

Function
REQ-019 Request = CPU_MIO & (MemRead | MemWrite); sampled only in state IDLE.
REQ-020 States SHALL be IDLE, RAM_WAIT, IO_WAIT, DONE; encoding 2 bits.
REQ-021 IDLE + request: register addr, wdata, op (write if MemWrite); go RAM_WAIT or IO_WAIT per REQ-003 decode.
REQ-022 MemRead and MemWrite both high: treat as write, set bus_err.
REQ-023 RAM_WAIT: ram_en high for first cycle only, ram_we high with it on writes; down-counter loaded with RAM_LAT; at count 0 capture ram_dout into rdata (reads), go DONE.
REQ-024 RAM access: MIO_ready high exactly RAM_LAT+1 edges after the sampling edge, for one cycle.
REQ-025 IO_WAIT: io_re or io_we held high with io_addr/io_wdata stable until io_ack sampled high; then capture io_rdata (reads), drop strobes, go DONE.
REQ-026 DONE: MIO_ready=1 for exactly one cycle, then IDLE; request not sampled in DONE.
REQ-027 Back-to-back: request present in the IDLE cycle after DONE SHALL be accepted with no extra bubble.
REQ-028 rdata SHALL hold its value until the next read completes; writes SHALL not alter rdata.
REQ-029 io_ack high while not in IO_WAIT SHALL be ignored.
REQ-030 bus_err cleared only by reset.

Reset
REQ-031 reset SHALL force IDLE immediately, aborting any access in progress.
REQ-032 Reset values: MIO_ready=0, rdata=0, ram_en=0, ram_we=0, io_re=0, io_we=0, bus_err=0, counters=0, ram_addr/ram_din/io_addr/io_wdata=0.
REQ-033 First request SHALL be sampled on the first rising edge after reset deasserts.

Configuration
REQ-034 Macro MIO_TIMEOUT_EN defined: IO_WAIT counts cycles; after IO_TIMEOUT cycles without io_ack, drop strobes, rdata=32'hFFFF_FFFF (reads), set bus_err, go DONE.
REQ-035 MIO_TIMEOUT_EN undefined: no counter; IO_WAIT waits for io_ack indefinitely; bus_err set only by REQ-022.

Verification
REQ-036 RAM_LAT=1, read addr 0x0000_0010, ram_dout=0x1234_5678 -> ram_addr=4, MIO_ready pulse 2 edges later, rdata=0x1234_5678.
REQ-037 Write addr 0xE000_0004, wdata=0xA5A5_A5A5, io_ack after 5 cycles -> io_we high 5 cycles, io_wdata=0xA5A5_A5A5, one MIO_ready pulse, rdata unchanged.
REQ-038 RAM write then immediate RAM read (store followed by fetch) -> second access starts in IDLE cycle after DONE, two MIO_ready pulses, no lost request.
REQ-039 MIO_TIMEOUT_EN, IO_TIMEOUT=8, IO read with no io_ack -> MIO_ready after 8 wait cycles, rdata=0xFFFF_FFFF, bus_err=1.
REQ-040 reset asserted mid-IO_WAIT -> io_re=0, MIO_ready=0, state IDLE same cycle; MemRead+MemWrite together -> write performed, bus_err=1.
